// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative multiply/divide engine owning the HI/LO register pair
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;
    localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     raw_rs_q, raw_rs_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo, rem;

    // Signed ops work on magnitudes; the signs are re-applied in FIX.
    assign rs_neg = ~op[0] & rs_val[WIDTH-1];
    assign rt_neg = ~op[0] & rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? (~rs_val + ONE_W) : rs_val;
    assign rt_mag = rt_neg ? (~rt_val + ONE_W) : rt_val;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, a_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], div_ge};

    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_q_q ? (~acc_q + ONE_2W) : acc_q;

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        a_d      = a_q;
        raw_rs_d = raw_rs_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    is_div_d = op[1];
                    dz_d     = op[1] & (rt_val == '0);
                    neg_q_d  = rs_neg ^ rt_neg;
                    neg_r_d  = rs_neg;
                    raw_rs_d = rs_val;
                    a_d      = op[1] ? rt_mag : rs_mag;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                    cnt_d    = '0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    lo_d = '1;
                    hi_d = raw_rs_q;
                end else begin
                    lo_d = neg_q_q ? (~quo + ONE_W) : quo;
                    hi_d = neg_r_q ? (~rem + ONE_W) : rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            a_q      <= '0;
            raw_rs_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            a_q      <= a_d;
            raw_rs_q <= raw_rs_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | hi_we | lo_we | mf_req);

endmodule
